// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: request-to-send, 8 data bits, odd parity,
// stop, then device acknowledge check, all paced by device clock falls.
// Ports: clk, rst_n (async, active-low); kclk_in/kdata_in async pad inputs;
//   kclk_oe/kdata_oe open-drain pull-low enables; start/data command request;
//   busy transaction flag; done one-cycle completion pulse; err NACK/timeout.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 10000,
    parameter int TIMEOUT_CYCLES = 1500000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       kclk_in,
    input  logic       kdata_in,
    output logic       kclk_oe,
    output logic       kdata_oe,
    input  logic       start,
    input  logic [7:0] data,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int MAXC = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ?
                          INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int TW = $clog2(MAXC + 1);
    localparam logic [TW-1:0] INH_LAST = TW'(INHIBIT_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_START,
        S_REQ,
        S_SHIFT,
        S_ACK,
        S_WAIT
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      kclk_sync_q;
    logic [1:0]      kdata_sync_q;
    logic            kclk_prev_q;
    logic [TW-1:0]   tmr_q, tmr_d;
    logic [3:0]      bitcnt_q, bitcnt_d;
    logic [9:0]      sr_q, sr_d;
    logic            nack_q, nack_d;
    logic            done_q, done_d;
    logic            err_q, err_d;

    logic kclk_s;
    logic kdata_s;
    logic fall;
    logic accept;
    logic wd_act;
    logic timeout;

    // Synchronizers reset to 1 (idle bus level) so reset never fakes a fall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kclk_sync_q  <= 2'b11;
            kdata_sync_q <= 2'b11;
            kclk_prev_q  <= 1'b1;
        end else begin
            kclk_sync_q  <= {kclk_sync_q[0], kclk_in};
            kdata_sync_q <= {kdata_sync_q[0], kdata_in};
            kclk_prev_q  <= kclk_sync_q[1];
        end
    end

    assign kclk_s  = kclk_sync_q[1];
    assign kdata_s = kdata_sync_q[1];
    assign fall    = kclk_prev_q & ~kclk_s;

    // A start coinciding with the done pulse is dropped.
    assign accept  = start & (state_q == S_IDLE) & ~done_q;

    assign wd_act  = (state_q == S_REQ) | (state_q == S_SHIFT) |
                     (state_q == S_ACK) | (state_q == S_WAIT);
    assign timeout = wd_act & ~fall & (tmr_q == TO_LAST);

    // State register and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            tmr_q    <= '0;
            bitcnt_q <= '0;
            sr_q     <= '0;
            nack_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            tmr_q    <= tmr_d;
            bitcnt_q <= bitcnt_d;
            sr_q     <= sr_d;
            nack_q   <= nack_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        tmr_d    = tmr_q;
        bitcnt_d = bitcnt_q;
        sr_d     = sr_q;
        nack_d   = nack_q;
        done_d   = 1'b0;
        err_d    = 1'b0;

        // Watchdog reloads on every device clock fall.
        if (wd_act) begin
            tmr_d = fall ? '0 : tmr_q + 1'b1;
        end

        if (timeout) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            err_d   = 1'b1;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        sr_d     = {1'b1, ~^data, data};
                        tmr_d    = '0;
                        bitcnt_d = '0;
                        nack_d   = 1'b0;
                        state_d  = S_INHIBIT;
                    end
                end
                S_INHIBIT: begin
                    if (tmr_q == INH_LAST) begin
                        tmr_d   = '0;
                        state_d = S_START;
                    end else begin
                        tmr_d = tmr_q + 1'b1;
                    end
                end
                S_START: begin
                    tmr_d   = '0;
                    state_d = S_REQ;
                end
                S_REQ: begin
                    if (fall) state_d = S_SHIFT;
                end
                S_SHIFT: begin
                    // Ninth shift puts the stop bit (released line) in sr_q[0].
                    if (fall) begin
                        sr_d     = {1'b1, sr_q[9:1]};
                        bitcnt_d = bitcnt_q + 4'd1;
                        if (bitcnt_q == 4'd8) state_d = S_ACK;
                    end
                end
                S_ACK: begin
                    if (fall) begin
                        nack_d  = kdata_s;
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (kclk_s && kdata_s) begin
                        done_d  = 1'b1;
                        err_d   = nack_q;
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Outputs decoded from the state register only, so reset releases the
    // lines immediately.
    always_comb begin
        kclk_oe  = 1'b0;
        kdata_oe = 1'b0;
        busy     = 1'b1;
        unique case (state_q)
            S_IDLE:    busy = 1'b0;
            S_INHIBIT: kclk_oe = 1'b1;
            S_START: begin
                kclk_oe  = 1'b1;
                kdata_oe = 1'b1;
            end
            S_REQ:     kdata_oe = 1'b1;
            S_SHIFT:   kdata_oe = ~sr_q[0];
            S_ACK:     kdata_oe = 1'b0;
            S_WAIT:    kdata_oe = 1'b0;
            default:   busy = 1'b0;
        endcase
    end

    assign done = done_q;
    assign err  = err_q;

endmodule
